// File: rtl/sc_gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// sc_gate_truth_table_checker
//
// On-board self-test for two-input combinational gates. The checker drives the
// gate's a/b inputs through the vectors 00, 01, 10, 11. It holds each vector
// for SETTLE_CYCLES cycles and then samples the gate output z for one cycle.
// Each sample is compared against EXPECTED_TT, indexed by {a,b}. When the run
// ends the checker reports a per-vector error mask and an overall pass flag.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..255)
//   EXPECTED_TT    expected z per vector, bit index = {a,b} (default AND)
//   CNT_WIDTH      settle counter width, must hold SETTLE_CYCLES-1
//
// Ports:
//   SC_GateCHECK_CLOCK_50      system clock, rising edge
//   SC_GateCHECK_RESET_InHigh  asynchronous reset, active-high
//   SC_GateCHECK_start_In      start request, only looked at while idle
//   SC_GateCHECK_z_In          output of the gate under test
//   SC_GateCHECK_a_Out         gate input a (registered)
//   SC_GateCHECK_b_Out         gate input b (registered)
//   SC_GateCHECK_busy_Out      high whenever a run is in progress
//   SC_GateCHECK_done_Out      one-cycle pulse at the end of a run
//   SC_GateCHECK_pass_Out      all four vectors matched, held until next start
//   SC_GateCHECK_errmask_Out   bit v set = mismatch on vector v
//   SC_GateCHECK_vector_Out    current vector index {a,b}
// -----------------------------------------------------------------------------
module sc_gate_truth_table_checker #(
   parameter int       SETTLE_CYCLES = 4,
   parameter bit [3:0] EXPECTED_TT   = 4'b1000,
   parameter int       CNT_WIDTH     = 8
) (
   input  logic       SC_GateCHECK_CLOCK_50,
   input  logic       SC_GateCHECK_RESET_InHigh,
   input  logic       SC_GateCHECK_start_In,
   input  logic       SC_GateCHECK_z_In,
   output logic       SC_GateCHECK_a_Out,
   output logic       SC_GateCHECK_b_Out,
   output logic       SC_GateCHECK_busy_Out,
   output logic       SC_GateCHECK_done_Out,
   output logic       SC_GateCHECK_pass_Out,
   output logic [3:0] SC_GateCHECK_errmask_Out,
   output logic [1:0] SC_GateCHECK_vector_Out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } checkState_t;

   localparam logic [CNT_WIDTH-1:0] settleLast  = CNT_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [3:0]           expectedTt  = EXPECTED_TT;

   checkState_t          state, stateNext;
   logic [1:0]           vector, vectorNext;
   logic [CNT_WIDTH-1:0] counter, counterNext;
   logic [1:0]           abReg, abNext;
   logic [3:0]           errmask, errmaskNext;
   logic                 pass, passNext;
   logic [3:0]           sampledMask;

   // State register plus every datapath register. Reset clears everything at
   // once, so an aborted run leaves no stale results and no done pulse.
   always_ff @(posedge SC_GateCHECK_CLOCK_50 or posedge SC_GateCHECK_RESET_InHigh) begin
      if (SC_GateCHECK_RESET_InHigh) begin
         state   <= IDLE;
         vector  <= 2'd0;
         counter <= '0;
         abReg   <= 2'd0;
         errmask <= 4'd0;
         pass    <= 1'b0;
      end else begin
         state   <= stateNext;
         vector  <= vectorNext;
         counter <= counterNext;
         abReg   <= abNext;
         errmask <= errmaskNext;
         pass    <= passNext;
      end
   end

   // Next-state and next-register logic. a/b are loaded with the same value as
   // the vector register on the same edge, so the gate sees the new vector as
   // soon as the index changes. The pass flag in SAMPLE is computed from
   // sampledMask, so it includes the result of the last vector.
   always_comb begin
      stateNext   = state;
      vectorNext  = vector;
      counterNext = counter;
      abNext      = abReg;
      errmaskNext = errmask;
      passNext    = pass;

      sampledMask         = errmask;
      sampledMask[vector] = (SC_GateCHECK_z_In != expectedTt[vector]);

      unique case (state)
         IDLE: begin
            abNext      = 2'd0;
            vectorNext  = 2'd0;
            counterNext = '0;
            if (SC_GateCHECK_start_In) begin
               stateNext   = SETTLE;
               errmaskNext = 4'd0;
               passNext    = 1'b0;
            end
         end
         SETTLE: begin
            abNext = vector;
            if (counter == settleLast) begin
               counterNext = '0;
               stateNext   = SAMPLE;
            end else begin
               counterNext = counter + 1'b1;
            end
         end
         SAMPLE: begin
            errmaskNext = sampledMask;
            if (vector == 2'd3) begin
               stateNext  = DONE;
               passNext   = (sampledMask == 4'd0);
               vectorNext = 2'd0;
               abNext     = 2'd0;
            end else begin
               stateNext  = SETTLE;
               vectorNext = vector + 2'd1;
               abNext     = vector + 2'd1;
            end
         end
         DONE: begin
            stateNext  = IDLE;
            vectorNext = 2'd0;
            abNext     = 2'd0;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Status outputs come straight from the state register. This keeps busy
   // and done glitch-free and makes both drop in the same cycle as a reset.
   always_comb begin
      SC_GateCHECK_busy_Out = (state != IDLE);
      SC_GateCHECK_done_Out = (state == DONE);
   end

   assign SC_GateCHECK_a_Out       = abReg[1];
   assign SC_GateCHECK_b_Out       = abReg[0];
   assign SC_GateCHECK_pass_Out    = pass;
   assign SC_GateCHECK_errmask_Out = errmask;
   assign SC_GateCHECK_vector_Out  = vector;

endmodule

// File: tb/tb_sc_gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// tb_sc_gate_truth_table_checker
//
// Directed bench for the gate truth-table checker. It uses three instances:
//   dut0 - default parameters; its z is driven by a selectable gate
//          (AND, constant 1 or OR)
//   dut1 - EXPECTED_TT = 4'b1110, checking an OR gate
//   dut2 - SETTLE_CYCLES = 1, checking an AND gate
// -----------------------------------------------------------------------------
module tb_sc_gate_truth_table_checker;

   logic clock = 1'b0;
   logic reset;

   logic start0, start1, start2;
   logic z0, z1, z2;
   logic a0, b0, busy0, done0, pass0;
   logic a1, b1, busy1, done1, pass1;
   logic a2, b2, busy2, done2, pass2;
   logic [3:0] errmask0, errmask1, errmask2;
   logic [1:0] vector0, vector1, vector2;

   // Gate model seen by dut0: 0 = AND, 1 = tied high, 2 = OR.
   int gateMode;

   int compared   = 0;
   int mismatched = 0;

   // Free-running 10-unit clock shared by all instances.
   always #5 clock = ~clock;

   // Gates under test, evaluated combinationally from each checker's a/b.
   always_comb begin
      z0 = 1'b0;
      case (gateMode)
         0:       z0 = a0 & b0;
         1:       z0 = 1'b1;
         default: z0 = a0 | b0;
      endcase
      z1 = a1 | b1;
      z2 = a2 & b2;
   end

   sc_gate_truth_table_checker dut0 (
      .SC_GateCHECK_CLOCK_50     (clock),
      .SC_GateCHECK_RESET_InHigh (reset),
      .SC_GateCHECK_start_In     (start0),
      .SC_GateCHECK_z_In         (z0),
      .SC_GateCHECK_a_Out        (a0),
      .SC_GateCHECK_b_Out        (b0),
      .SC_GateCHECK_busy_Out     (busy0),
      .SC_GateCHECK_done_Out     (done0),
      .SC_GateCHECK_pass_Out     (pass0),
      .SC_GateCHECK_errmask_Out  (errmask0),
      .SC_GateCHECK_vector_Out   (vector0)
   );

   sc_gate_truth_table_checker #(.EXPECTED_TT(4'b1110)) dut1 (
      .SC_GateCHECK_CLOCK_50     (clock),
      .SC_GateCHECK_RESET_InHigh (reset),
      .SC_GateCHECK_start_In     (start1),
      .SC_GateCHECK_z_In         (z1),
      .SC_GateCHECK_a_Out        (a1),
      .SC_GateCHECK_b_Out        (b1),
      .SC_GateCHECK_busy_Out     (busy1),
      .SC_GateCHECK_done_Out     (done1),
      .SC_GateCHECK_pass_Out     (pass1),
      .SC_GateCHECK_errmask_Out  (errmask1),
      .SC_GateCHECK_vector_Out   (vector1)
   );

   sc_gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut2 (
      .SC_GateCHECK_CLOCK_50     (clock),
      .SC_GateCHECK_RESET_InHigh (reset),
      .SC_GateCHECK_start_In     (start2),
      .SC_GateCHECK_z_In         (z2),
      .SC_GateCHECK_a_Out        (a2),
      .SC_GateCHECK_b_Out        (b2),
      .SC_GateCHECK_busy_Out     (busy2),
      .SC_GateCHECK_done_Out     (done2),
      .SC_GateCHECK_pass_Out     (pass2),
      .SC_GateCHECK_errmask_Out  (errmask2),
      .SC_GateCHECK_vector_Out   (vector2)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulse start on dut0 so it is sampled at the next edge (run edge 0).
   task automatic applyStimulus();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
   endtask

   // Walk dut0 from just after run edge 0 to just after run edge 20. Each
   // vector n/5 is held for 5 cycles. With noisy set, start toggles during
   // the run and is left high going into DONE.
   task automatic runBody(input string tag, input bit noisy);
      for (int n = 0; n < 20; n++) begin
         checkOutput({tag, ".vector"}, 32'(vector0), n / 5);
         checkOutput({tag, ".ab"}, 32'({a0, b0}), n / 5);
         checkOutput({tag, ".busy"}, 32'(busy0), 1);
         checkOutput({tag, ".done"}, 32'(done0), 0);
         if (noisy) start0 = (n % 3 == 1) || (n == 19);
         tick();
      end
      checkOutput({tag, ".doneAt20"}, 32'(done0), 1);
      checkOutput({tag, ".busyAt20"}, 32'(busy0), 1);
      checkOutput({tag, ".abAt20"}, 32'({a0, b0}), 0);
      checkOutput({tag, ".vectorAt20"}, 32'(vector0), 0);
   endtask

   initial begin
      bit sawDone;
      reset    = 1'b1;
      start0   = 1'b0;
      start1   = 1'b0;
      start2   = 1'b0;
      gateMode = 0;
      tick();
      tick();

      // Reset state
      checkOutput("rst.a", 32'(a0), 0);
      checkOutput("rst.b", 32'(b0), 0);
      checkOutput("rst.busy", 32'(busy0), 0);
      checkOutput("rst.done", 32'(done0), 0);
      checkOutput("rst.pass", 32'(pass0), 0);
      checkOutput("rst.errmask", 32'(errmask0), 0);
      checkOutput("rst.vector", 32'(vector0), 0);
      reset = 1'b0;
      tick();

      // Correct AND gate
      gateMode = 0;
      applyStimulus();
      runBody("and", 1'b0);
      checkOutput("and.errmask", 32'(errmask0), 'h0);
      checkOutput("and.pass", 32'(pass0), 1);
      tick();
      checkOutput("and.busyAfter", 32'(busy0), 0);
      checkOutput("and.doneAfter", 32'(done0), 0);
      checkOutput("and.passHeld", 32'(pass0), 1);
      tick();

      // z stuck high: vectors 00, 01 and 10 mismatch
      gateMode = 1;
      applyStimulus();
      runBody("one", 1'b0);
      checkOutput("one.errmask", 32'(errmask0), 'h7);
      checkOutput("one.pass", 32'(pass0), 0);
      tick();

      // OR gate against the default AND table: vectors 01 and 10 mismatch
      gateMode = 2;
      applyStimulus();
      runBody("or", 1'b0);
      checkOutput("or.errmask", 32'(errmask0), 'h6);
      checkOutput("or.pass", 32'(pass0), 0);
      tick();

      // OR gate against an OR table on dut1
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int n = 0; n < 19; n++) tick();
      checkOutput("orTT.done", 32'(done1), 0);
      tick();
      checkOutput("orTT.doneAt20", 32'(done1), 1);
      checkOutput("orTT.errmask", 32'(errmask1), 'h0);
      checkOutput("orTT.pass", 32'(pass1), 1);
      tick();
      checkOutput("orTT.busyAfter", 32'(busy1), 0);

      // Asynchronous reset while vector 2 is settling, with z stuck high
      gateMode = 1;
      applyStimulus();
      for (int n = 0; n < 11; n++) tick();
      checkOutput("abort.preVector", 32'(vector0), 2);
      checkOutput("abort.preErrmask", 32'(errmask0), 'h3);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort.a", 32'(a0), 0);
      checkOutput("abort.b", 32'(b0), 0);
      checkOutput("abort.busy", 32'(busy0), 0);
      checkOutput("abort.vector", 32'(vector0), 0);
      checkOutput("abort.errmask", 32'(errmask0), 0);
      checkOutput("abort.pass", 32'(pass0), 0);
      tick();
      reset = 1'b0;
      sawDone = 1'b0;
      for (int n = 0; n < 25; n++) begin
         tick();
         if (done0 || busy0) sawDone = 1'b1;
      end
      checkOutput("abort.noDone", 32'(sawDone), 0);
      gateMode = 0;
      applyStimulus();
      runBody("afterAbort", 1'b0);
      checkOutput("afterAbort.pass", 32'(pass0), 1);
      tick();
      tick();

      // Start pulsed during the run and held high across DONE
      gateMode = 2;
      applyStimulus();
      runBody("noisy", 1'b1);
      checkOutput("noisy.errmask", 32'(errmask0), 'h6);
      checkOutput("noisy.pass", 32'(pass0), 0);
      tick();
      checkOutput("noisy.idleBusy", 32'(busy0), 0);
      checkOutput("noisy.idleErrmask", 32'(errmask0), 'h6);
      tick();
      checkOutput("noisy.restartBusy", 32'(busy0), 1);
      checkOutput("noisy.restartErrmask", 32'(errmask0), 0);
      checkOutput("noisy.restartPass", 32'(pass0), 0);
      start0   = 1'b0;
      gateMode = 0;
      runBody("second", 1'b0);
      checkOutput("second.errmask", 32'(errmask0), 'h0);
      checkOutput("second.pass", 32'(pass0), 1);
      tick();

      // SETTLE_CYCLES = 1: each vector is held 2 cycles, done after edge 8
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int n = 0; n < 8; n++) begin
         checkOutput("fast.vector", 32'(vector2), n / 2);
         checkOutput("fast.ab", 32'({a2, b2}), n / 2);
         checkOutput("fast.done", 32'(done2), 0);
         tick();
      end
      checkOutput("fast.doneAt8", 32'(done2), 1);
      checkOutput("fast.pass", 32'(pass2), 1);
      checkOutput("fast.errmask", 32'(errmask2), 'h0);
      tick();
      checkOutput("fast.busyAfter", 32'(busy2), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
